// File: rtl/xadc_drp_scan_ctrl.sv
// XADC DRP sequencer: EOS-triggered AUX0..3 scans with averaging and argmax,
// arbitrated against single config writes from the register block.
module xadc_drp_scan_ctrl #(
  parameter logic [6:0] AUX_BASE_ADDR  = 7'h10,
  parameter int         AVG_LOG2       = 2,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        enable,
  input  logic        eos,
  input  logic        cfg_wr_req,
  input  logic [6:0]  cfg_wr_addr,
  input  logic [15:0] cfg_wr_data,
  output logic        cfg_wr_ack,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] do_data,
  input  logic        drdy,
  output logic [11:0] measured_aux0,
  output logic [11:0] measured_aux1,
  output logic [11:0] measured_aux2,
  output logic [11:0] measured_aux3,
  output logic [1:0]  network_output,
  output logic        sample_valid,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state;
  logic          pending;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [15:0]   tmo;
  logic [AW-1:0] acc  [4];
  logic [11:0]   scan [4];
  logic [AW-1:0] sum  [4];
  logic [11:0]   avg  [4];
  logic [1:0]    best;
  logic          tmo_hit;
  logic          unused_lsb;

  assign unused_lsb = ^do_data[3:0];

  always_comb begin
    den        = (state == S_WR_ISSUE) || (state == S_RD_ISSUE);
    dwe        = (state == S_WR_ISSUE);
    tmo_hit    = ((state == S_WR_WAIT) || (state == S_RD_WAIT))
               && !drdy && (tmo == TMO_LAST);
    cfg_wr_ack = (state == S_WR_WAIT) && (drdy || tmo_hit);
    best       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = acc[i] + AW'(scan[i]);
      avg[i] = sum[i][AW-1:AVG_LOG2];
    end
    // strict compare keeps the lowest index on ties
    for (int i = 1; i < 4; i++) begin
      if (avg[i] > avg[best]) best = 2'(i);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= S_IDLE;
      pending        <= 1'b0;
      idx            <= 2'd0;
      cnt            <= '0;
      tmo            <= 16'd0;
      daddr          <= 7'd0;
      di             <= 16'd0;
      measured_aux0  <= 12'd0;
      measured_aux1  <= 12'd0;
      measured_aux2  <= 12'd0;
      measured_aux3  <= 12'd0;
      network_output <= 2'd0;
      sample_valid   <= 1'b0;
      timeout_err    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc[i]  <= '0;
        scan[i] <= 12'd0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (eos && enable) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!enable) begin
            pending <= 1'b0;
            idx     <= 2'd0;
            cnt     <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
          end
          if (cfg_wr_req) begin
            state <= S_WR_ISSUE;
            daddr <= cfg_wr_addr;
            di    <= cfg_wr_data;
          end else if (enable && (pending || eos)) begin
            state   <= S_RD_ISSUE;
            daddr   <= AUX_BASE_ADDR;
            pending <= 1'b0;
          end
        end
        S_WR_ISSUE: begin
          state <= S_WR_WAIT;
          tmo   <= 16'd0;
        end
        S_WR_WAIT: begin
          tmo <= tmo + 16'd1;
          if (drdy || tmo_hit) state <= S_IDLE;
        end
        S_RD_ISSUE: begin
          state <= S_RD_WAIT;
          tmo   <= 16'd0;
        end
        S_RD_WAIT: begin
          tmo <= tmo + 16'd1;
          if (drdy) begin
            scan[idx] <= do_data[15:4];
            if (!enable) begin
              state <= S_IDLE;
              idx   <= 2'd0;
            end else if (idx == 2'd3) begin
              state <= S_DONE;
              idx   <= 2'd0;
            end else begin
              state <= S_RD_ISSUE;
              idx   <= idx + 2'd1;
              daddr <= AUX_BASE_ADDR + 7'(idx) + 7'd1;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
            idx   <= 2'd0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (cnt == CNT_LAST) begin
            measured_aux0  <= avg[0];
            measured_aux1  <= avg[1];
            measured_aux2  <= avg[2];
            measured_aux3  <= avg[3];
            network_output <= best;
            sample_valid   <= 1'b1;
            cnt            <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            for (int i = 0; i < 4; i++) acc[i] <= sum[i];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
